// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD controller.
//   lcd_state_e        : bus-cycle FSM states
//   ADDR_*             : Avalon register map (bit1 = RS, bit0 = RW)
//   Def*               : default LCD timing, in clk cycles
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEhigh,
        StHold,
        StDone
    } lcd_state_e;

    localparam logic [1:0] ADDR_CMD_W  = 2'd0;
    localparam logic [1:0] ADDR_STAT_R = 2'd1;
    localparam logic [1:0] ADDR_DATA_W = 2'd2;
    localparam logic [1:0] ADDR_DATA_R = 2'd3;

    localparam int unsigned DefTAs  = 2;
    localparam int unsigned DefTPw  = 12;
    localparam int unsigned DefTH   = 2;
    localparam int unsigned DefCntW = 8;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one LCD bus phase.
//   clk_i       : clock
//   reset_i     : synchronous active-high reset
//   load_i      : load load_val_i this cycle (phase entry)
//   load_val_i  : phase length minus one
//   zero_o      : high in the last cycle of the phase
module lcd_phase_timer #(
    parameter int unsigned CntW = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            zero_o
);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Avalon-MM slave that runs timed HD44780 bus cycles and stalls the master until each completes.
//   clk, reset           : clock, synchronous active-high reset
//   address              : bit1 -> LCD_RS; direction comes from read/write
//   read, write          : Avalon strobes (both high performs a write)
//   writedata            : byte sent to the LCD
//   readdata             : byte captured as E falls, held until the next read
//   waitrequest          : stall, low only in the completion cycle
//   LCD_E/LCD_RS/LCD_RW  : LCD control pins (registered)
//   LCD_data             : LCD data bus; in 4-bit mode only [7:4] carry data, high nibble first
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS  = DefTAs,
    parameter int unsigned T_PW  = DefTPw,
    parameter int unsigned T_H   = DefTH,
    parameter bit          BUS4  = 1'b0,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam logic [CNT_W-1:0] LdAs = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LdPw = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LdH  = CNT_W'(T_H - 1);

    lcd_state_e       state_q, state_d;
    logic             req;
    logic             zero;
    logic             load;
    logic [CNT_W-1:0] load_val;

    logic       e_q, rs_q, rw_q, oe_q, nib_q;
    logic [7:0] dout_q, rdata_q;
    logic [3:0] wlo_q;  // low nibble kept for the second 4-bit phase

    // Direction is taken from the strobes, so address[0] is informational only.
    logic unused_addr_rw;
    assign unused_addr_rw = address[0];

    assign req = read | write;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req)  state_d = StSetup;
            StSetup: if (zero) state_d = StEhigh;
            StEhigh: if (zero) state_d = StHold;
            StHold:  if (zero) state_d = (BUS4 && !nib_q) ? StSetup : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Every state change reloads the timer with the new phase length.
    assign load = (state_d != state_q);

    always_comb begin
        load_val = '0;
        unique case (state_d)
            StSetup: load_val = LdAs;
            StEhigh: load_val = LdPw;
            StHold:  load_val = LdH;
            default: load_val = '0;
        endcase
    end

    lcd_phase_timer #(
        .CntW (CNT_W)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .zero_o     (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            nib_q   <= 1'b0;
            dout_q  <= 8'h00;
            wlo_q   <= 4'h0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        rs_q   <= address[1];
                        rw_q   <= read & ~write;
                        oe_q   <= ~(read & ~write);
                        nib_q  <= 1'b0;
                        wlo_q  <= writedata[3:0];
                        dout_q <= BUS4 ? {writedata[7:4], 4'h0} : writedata;
                    end
                end
                StSetup: begin
                    if (zero) e_q <= 1'b1;
                end
                StEhigh: begin
                    if (zero) begin
                        // Capture coincides with the falling edge of E.
                        e_q <= 1'b0;
                        if (rw_q) begin
                            if (!BUS4)      rdata_q      <= LCD_data;
                            else if (!nib_q) rdata_q[7:4] <= LCD_data[7:4];
                            else            rdata_q[3:0] <= LCD_data[7:4];
                        end
                    end
                end
                StHold: begin
                    if (zero) begin
                        if (BUS4 && !nib_q) begin
                            nib_q  <= 1'b1;
                            dout_q <= {wlo_q, 4'h0};
                        end else begin
                            oe_q <= 1'b0;
                        end
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

    assign waitrequest = req & (state_q != StDone);
    assign readdata    = rdata_q;
    assign LCD_E       = e_q;
    assign LCD_RS      = rs_q;
    assign LCD_RW      = rw_q;
    assign LCD_data    = oe_q ? dout_q : 8'hzz;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: an 8-bit instance (index 0) and a 4-bit instance (index 1).
// A master task issues transfers and queues expected completions and LCD pulses; a monitor
// on the falling clock edge checks completions and every E pulse against those queues.
module tb_lcd_hd44780_ctrl;

    localparam int unsigned TAs  = 2;
    localparam int unsigned TPw  = 12;
    localparam int unsigned TH   = 2;
    localparam int unsigned Lat8 = 1 + TAs + TPw + TH;
    localparam int unsigned Lat4 = 1 + 2 * (TAs + TPw + TH);

    typedef struct {
        int unsigned start;
        int unsigned lat;
        logic [7:0]  rdata;
    } txn_t;

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]      rd    = '0;
    logic [1:0]      wr    = '0;
    logic [1:0][1:0] addr  = '0;
    logic [1:0][7:0] wdata = '0;
    logic [1:0][7:0] rdata;
    logic [1:0]      wreq, lcd_e, lcd_rs, lcd_rw;
    wire  [7:0]      lcd_d0, lcd_d1;
    logic [1:0][7:0] bus;

    // Undriven bus reads as 0xFF.
    pullup (lcd_d0);
    pullup (lcd_d1);

    // LCD model: returns rbyte while E is high on a read; 4-bit model sends high nibble first
    // with junk on the unused low lines.
    logic [1:0][7:0] rbyte   = '0;
    logic [1:0]      nib_sel = '0;
    logic [7:0]      drv0, drv1;
    assign drv0   = rbyte[0];
    assign drv1   = nib_sel[1] ? {rbyte[1][3:0], 4'hA} : {rbyte[1][7:4], 4'h5};
    assign lcd_d0 = (lcd_rw[0] && lcd_e[0]) ? drv0 : 8'hzz;
    assign lcd_d1 = (lcd_rw[1] && lcd_e[1]) ? drv1 : 8'hzz;
    assign bus[0] = lcd_d0;
    assign bus[1] = lcd_d1;

    lcd_hd44780_ctrl #(
        .T_AS (TAs), .T_PW (TPw), .T_H (TH), .BUS4 (1'b0), .CNT_W (8)
    ) u_dut8 (
        .clk (clk), .reset (reset), .address (addr[0]), .read (rd[0]), .write (wr[0]),
        .writedata (wdata[0]), .readdata (rdata[0]), .waitrequest (wreq[0]),
        .LCD_E (lcd_e[0]), .LCD_RS (lcd_rs[0]), .LCD_RW (lcd_rw[0]), .LCD_data (lcd_d0)
    );

    lcd_hd44780_ctrl #(
        .T_AS (TAs), .T_PW (TPw), .T_H (TH), .BUS4 (1'b1), .CNT_W (8)
    ) u_dut4 (
        .clk (clk), .reset (reset), .address (addr[1]), .read (rd[1]), .write (wr[1]),
        .writedata (wdata[1]), .readdata (rdata[1]), .waitrequest (wreq[1]),
        .LCD_E (lcd_e[1]), .LCD_RS (lcd_rs[1]), .LCD_RW (lcd_rw[1]), .LCD_data (lcd_d1)
    );

    txn_t            sbq [2][$];
    ev_t             evq [2][$];
    logic [1:0][7:0] last_rd = '0;
    int              checks  = 0;
    int              errors  = 0;

    function automatic void chk(input string name, input int s, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=0x%0h required=0x%0h", name, s, act, exp);
        end
    endfunction

    // One LCD transaction seen at the pins: one E pulse (8-bit) or two nibble pulses (4-bit).
    function automatic void push_events(input int s, input logic is_rd, input logic rs,
                                        input logic [7:0] d);
        ev_t ev;
        ev.rs = rs;
        ev.rw = is_rd;
        if (s == 0) begin
            ev.d = d;
            evq[s].push_back(ev);
        end else begin
            ev.d = {d[7:4], 4'h0};
            evq[s].push_back(ev);
            ev.d = {d[3:0], 4'h0};
            evq[s].push_back(ev);
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic xfer(input int s, input logic r, input logic w, input logic [1:0] a,
                        input logic [7:0] d, input logic [7:0] rb, input logic hold);
        txn_t t;
        logic is_rd;
        logic done;
        is_rd    = r & ~w;
        rbyte[s] = rb;
        rd[s]    = r;
        wr[s]    = w;
        addr[s]  = a;
        wdata[s] = d;
        t.start  = cyc;
        t.lat    = (s == 0) ? Lat8 : Lat4;
        if (is_rd) last_rd[s] = rb;
        t.rdata  = last_rd[s];
        sbq[s].push_back(t);
        push_events(s, is_rd, a[1], d);
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!wreq[s]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout[%0d] actual=stalled required=done", s);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            rd[s] = 1'b0;
            wr[s] = 1'b0;
        end
    endtask

    int unsigned     hi_cnt [2];
    int unsigned     lo_cnt [2];
    int unsigned     last_gap [2];
    logic [1:0]      e_prev = '0;
    logic [1:0]      seen   = '0;
    logic [1:0][7:0] hi_bus;
    txn_t            mt;
    ev_t             me;

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                e_prev[s] = 1'b0;
                seen[s]   = 1'b0;
            end else begin
                if ((rd[s] | wr[s]) && !wreq[s]) begin
                    if (sbq[s].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected[%0d] actual=done required=none", s);
                    end else begin
                        mt = sbq[s].pop_front();
                        chk("latency", s, cyc - mt.start, mt.lat);
                        chk("readdata", s, rdata[s], mt.rdata);
                        chk("bus_z_done", s, bus[s], 8'hFF);
                    end
                end
                if (lcd_e[s]) begin
                    if (!e_prev[s]) begin
                        if (seen[s]) begin
                            last_gap[s] = lo_cnt[s];
                            chk("e_low_min", s, lo_cnt[s] >= TH + TAs, 1);
                        end
                        hi_cnt[s] = 1;
                    end else begin
                        hi_cnt[s]++;
                    end
                    hi_bus[s] = bus[s];
                end else if (e_prev[s]) begin
                    seen[s]   = 1'b1;
                    lo_cnt[s] = 1;
                    if (evq[s].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL e_pulse[%0d] actual=unexpected required=none", s);
                    end else begin
                        me = evq[s].pop_front();
                        chk("e_width", s, hi_cnt[s], TPw);
                        chk("lcd_rs", s, lcd_rs[s], me.rs);
                        chk("lcd_rw", s, lcd_rw[s], me.rw);
                        if (!me.rw) chk("lcd_wdata", s, hi_bus[s], me.d);
                    end
                    if (s == 1 && lcd_rw[s]) nib_sel[1] = ~nib_sel[1];
                end else begin
                    lo_cnt[s]++;
                end
                e_prev[s] = lcd_e[s];
            end
        end
    end

    int          rs_sel, op, prev_s;
    logic        hold, prev_hold, got_e;
    logic [7:0]  d8;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_e", s, lcd_e[s], 0);
            chk("rst_rs", s, lcd_rs[s], 0);
            chk("rst_rw", s, lcd_rw[s], 0);
            chk("rst_rdata", s, rdata[s], 8'h00);
            chk("rst_wreq", s, wreq[s], 0);
            chk("rst_bus_z", s, bus[s], 8'hFF);
        end
        @(posedge clk);
        #1;

        // Directed cases from the plan.
        xfer(0, 1'b0, 1'b1, 2'd0, 8'h38, 8'h00, 1'b0);
        xfer(0, 1'b1, 1'b0, 2'd1, 8'h00, 8'h80, 1'b0);
        xfer(1, 1'b0, 1'b1, 2'd2, 8'hA5, 8'h00, 1'b0);
        xfer(1, 1'b1, 1'b0, 2'd3, 8'h00, 8'h41, 1'b0);
        // Read and write together performs a write.
        xfer(1, 1'b1, 1'b1, 2'd1, 8'h3C, 8'h99, 1'b0);
        xfer(0, 1'b1, 1'b1, 2'd2, 8'hC3, 8'h99, 1'b0);

        // Reset while E is high during a write.
        wr[0] = 1'b1; addr[0] = 2'd2; wdata[0] = 8'h5A;
        got_e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_e[0]) begin
                got_e = 1'b1;
                break;
            end
        end
        chk("rst_test_e_seen", 0, got_e, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_e", 0, lcd_e[0], 0);
        chk("midrst_bus_z", 0, bus[0], 8'hFF);
        chk("midrst_wreq", 0, wreq[0], 1);
        chk("midrst_rdata0", 0, rdata[0], 8'h00);
        chk("midrst_rdata1", 1, rdata[1], 8'h00);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        wr[0]   = 1'b0;
        last_rd = '0;
        @(negedge clk);
        chk("midrst_wreq_drop", 0, wreq[0], 0);
        repeat (4) @(negedge clk);
        chk("midrst_idle_e", 0, lcd_e[0], 0);
        @(posedge clk);
        #1;

        // Back-to-back writes with write held across DONE.
        xfer(0, 1'b0, 1'b1, 2'd0, 8'h01, 8'h00, 1'b1);
        xfer(0, 1'b0, 1'b1, 2'd0, 8'h0C, 8'h00, 1'b0);
        chk("b2b_e_gap", 0, last_gap[0], TH + TAs + 2);

        // One-cycle request: the LCD cycle still runs, the DONE cycle is ignored.
        wr[0] = 1'b1; addr[0] = 2'd2; wdata[0] = 8'h6E;
        push_events(0, 1'b0, 1'b1, 8'h6E);
        @(posedge clk);
        #1 wr[0] = 1'b0;
        repeat (Lat8 + 4) @(posedge clk);
        #1;
        chk("short_req_pulse", 0, evq[0].size(), 0);

        // Randomised traffic on both widths.
        prev_hold = 1'b0;
        prev_s    = 0;
        for (int i = 0; i < 40; i++) begin
            rs_sel = prev_hold ? prev_s : int'($urandom_range(0, 1));
            op     = int'($urandom_range(0, 3));
            hold   = ($urandom_range(0, 3) == 0);
            d8     = 8'($urandom);
            if (!prev_hold) repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            xfer(rs_sel, op >= 2, op != 2, 2'($urandom), d8, 8'($urandom), hold);
            prev_hold = hold;
            prev_s    = rs_sel;
        end
        rd = '0;
        wr = '0;
        repeat (Lat4 + 4) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("evq_drained", s, evq[s].size(), 0);
            chk("sbq_drained", s, sbq[s].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
